// File: rtl/cdb_arbiter.sv
// CDB / address-bus arbiter: one zero-latency grant per cycle to an FU output buffer.
// Round-robin within the highest non-empty tier: starved, then full, then any request.
module cdb_arbiter #(
   parameter int N_REQ        = 4,
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_WIDTH    = 4,
   parameter int IDX_WIDTH    = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     request,
   input  logic [N_REQ-1:0]     full,
   input  logic                 bus_stall,
   output logic [N_REQ-1:0]     permit,
   output logic                 bus_valid,
   output logic [IDX_WIDTH-1:0] grant_index,
   output logic [N_REQ-1:0]     starved
);

   logic [IDX_WIDTH-1:0] r_last_grant;
   logic [CNT_WIDTH-1:0] r_wait_cnt [N_REQ];

   logic [N_REQ-1:0]     w_eligible;
   logic [N_REQ-1:0]     w_starved;
   logic [N_REQ-1:0]     w_tier1;
   logic [N_REQ-1:0]     w_tier2;
   logic [N_REQ-1:0]     w_tier;
   logic [N_REQ-1:0]     w_permit;
   logic                 w_found;
   logic [IDX_WIDTH-1:0] w_grant_idx;

   // Gating with reset keeps every output quiet while reset is held, not just after an edge.
   assign w_eligible = reset ? '0 : (request & ~{N_REQ{bus_stall}});

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_req
         assign w_starved[gi] = !reset && request[gi] &&
                                (r_wait_cnt[gi] >= CNT_WIDTH'(STARVE_LIMIT));
         assign w_permit[gi]  = w_found && (w_grant_idx == IDX_WIDTH'(gi));
      end
   endgenerate

   assign w_tier1 = w_eligible & w_starved;
   assign w_tier2 = w_eligible & full;
   assign w_tier  = (|w_tier1) ? w_tier1 : ((|w_tier2) ? w_tier2 : w_eligible);

   // Wrap by subtraction so non-power-of-two N_REQ never visits an out-of-range index.
   always_comb begin
      int v_idx;
      w_found     = 1'b0;
      w_grant_idx = '0;
      v_idx       = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         v_idx = int'(r_last_grant) + k;
         if (v_idx >= N_REQ) v_idx = v_idx - N_REQ;
         if (!w_found && w_tier[v_idx]) begin
            w_found     = 1'b1;
            w_grant_idx = IDX_WIDTH'(v_idx);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last_grant <= IDX_WIDTH'(N_REQ - 1);
      end else if (w_found) begin
         r_last_grant <= w_grant_idx;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_REQ; i++) r_wait_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!request[i] || w_permit[i])
               r_wait_cnt[i] <= '0;
            else if (bus_stall)
               r_wait_cnt[i] <= r_wait_cnt[i];
            else if (r_wait_cnt[i] != {CNT_WIDTH{1'b1}})
               r_wait_cnt[i] <= r_wait_cnt[i] + CNT_WIDTH'(1);
         end
      end
   end

   assign permit      = w_permit;
   assign bus_valid   = w_found;
   assign grant_index = w_grant_idx;
   assign starved     = w_starved;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table on a 4-requester instance (STARVE_LIMIT=3)
// and a randomized model-checked run on a 3-requester instance.
module tb_cdb_arbiter;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // 4-requester instance, short starvation limit
   logic [3:0] req4, full4, permit4, starved4;
   logic       stall4, valid4;
   logic [1:0] idx4;

   cdb_arbiter #(.N_REQ(4), .STARVE_LIMIT(3), .CNT_WIDTH(4)) u_dut4 (
      .clk(clk), .reset(reset), .request(req4), .full(full4), .bus_stall(stall4),
      .permit(permit4), .bus_valid(valid4), .grant_index(idx4), .starved(starved4)
   );

   // 3-requester instance, default starvation limit
   logic [2:0] req3, full3, permit3, starved3;
   logic       stall3, valid3;
   logic [1:0] idx3;

   cdb_arbiter #(.N_REQ(3), .STARVE_LIMIT(8), .CNT_WIDTH(4)) u_dut3 (
      .clk(clk), .reset(reset), .request(req3), .full(full3), .bus_stall(stall3),
      .permit(permit3), .bus_valid(valid3), .grant_index(idx3), .starved(starved3)
   );

   typedef struct {
      bit         rst_before;
      logic [3:0] req;
      logic [3:0] full;
      logic       stall;
      logic [3:0] exp_permit;
      logic [1:0] exp_idx;
      logic       exp_valid;
      logic [3:0] exp_starved;
   } vec_t;

   typedef struct {
      logic [2:0] permit;
      logic [1:0] idx;
      logic       valid;
      logic [2:0] starved;
   } exp3_t;

   int tests = 0;
   int fails = 0;
   vec_t  vecs[20];
   vec_t  q4[$];
   exp3_t q3[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(bit r, logic [3:0] rq, logic [3:0] fl, logic st,
                               logic v, logic [1:0] idx, logic [3:0] sv);
      vec_t x;
      x.rst_before  = r;
      x.req         = rq;
      x.full        = fl;
      x.stall       = st;
      x.exp_valid   = v;
      x.exp_idx     = v ? idx : 2'd0;
      x.exp_permit  = v ? (4'b0001 << idx) : 4'b0000;
      x.exp_starved = sv;
      return x;
   endfunction

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int    m_cnt[3];
      int    m_wait[3];
      int    m_lg;
      int    worst;
      vec_t  v;
      exp3_t e;
      logic [2:0] elig, st3, t1, t2, tier;

      // round-robin from reset, starvation rotating with STARVE_LIMIT=3
      vecs[0]  = mk(1, 4'b1111, 4'b0000, 0, 1, 0, 4'b0000);
      vecs[1]  = mk(0, 4'b1111, 4'b0000, 0, 1, 1, 4'b0000);
      vecs[2]  = mk(0, 4'b1111, 4'b0000, 0, 1, 2, 4'b0000);
      vecs[3]  = mk(0, 4'b1111, 4'b0000, 0, 1, 3, 4'b1000);
      vecs[4]  = mk(0, 4'b1111, 4'b0000, 0, 1, 0, 4'b0001);
      vecs[5]  = mk(0, 4'b1111, 4'b0000, 0, 1, 1, 4'b0010);
      vecs[6]  = mk(0, 4'b1111, 4'b0000, 0, 1, 2, 4'b0100);
      vecs[7]  = mk(0, 4'b1111, 4'b0000, 0, 1, 3, 4'b1000);
      // full tier beats round-robin order, then round-robin resumes from 2
      vecs[8]  = mk(1, 4'b0001, 4'b0000, 0, 1, 0, 4'b0000);
      vecs[9]  = mk(0, 4'b1111, 4'b0100, 0, 1, 2, 4'b0000);
      vecs[10] = mk(0, 4'b1111, 4'b0000, 0, 1, 3, 4'b0000);
      // starvation overrides full
      vecs[11] = mk(1, 4'b0011, 4'b0001, 0, 1, 0, 4'b0000);
      vecs[12] = mk(0, 4'b0011, 4'b0001, 0, 1, 0, 4'b0000);
      vecs[13] = mk(0, 4'b0011, 4'b0001, 0, 1, 0, 4'b0000);
      vecs[14] = mk(0, 4'b0011, 4'b0001, 0, 1, 1, 4'b0010);
      vecs[15] = mk(0, 4'b0011, 4'b0001, 0, 1, 0, 4'b0000);
      // bus_stall freezes arbitration
      vecs[16] = mk(1, 4'b1010, 4'b0000, 1, 0, 0, 4'b0000);
      vecs[17] = mk(0, 4'b1010, 4'b0000, 1, 0, 0, 4'b0000);
      vecs[18] = mk(0, 4'b1010, 4'b0000, 0, 1, 1, 4'b0000);
      vecs[19] = mk(0, 4'b1010, 4'b0000, 0, 1, 3, 4'b0000);

      reset = 1'b1;
      req4 = 4'b1111; full4 = 4'b0000; stall4 = 1'b0;
      req3 = 3'b000;  full3 = 3'b000;  stall3 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_permit",  permit4,  4'b0000);
      chk("reset_valid",   valid4,   1'b0);
      chk("reset_idx",     idx4,     2'd0);
      chk("reset_starved", starved4, 4'b0000);
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = 0; i < 20; i++) begin
         if (vecs[i].rst_before) pulse_reset();
         req4   = vecs[i].req;
         full4  = vecs[i].full;
         stall4 = vecs[i].stall;
         q4.push_back(vecs[i]);
         @(negedge clk);
         v = q4.pop_front();
         chk($sformatf("vec%0d_permit", i),  permit4,  v.exp_permit);
         chk($sformatf("vec%0d_idx", i),     idx4,     v.exp_idx);
         chk($sformatf("vec%0d_valid", i),   valid4,   v.exp_valid);
         chk($sformatf("vec%0d_starved", i), starved4, v.exp_starved);
         $display("[TB] vec %0d req=%b full=%b stall=%b -> permit=%b idx=%0d",
                  i, req4, full4, stall4, permit4, idx4);
         @(posedge clk);
         #1;
      end

      // asynchronous reset between edges drops the grant immediately
      pulse_reset();
      req4 = 4'b0100; full4 = 4'b0000; stall4 = 1'b0;
      @(negedge clk);
      chk("async_pre_idx", idx4, 2'd2);
      chk("async_pre_permit", permit4, 4'b0100);
      #2;
      reset = 1'b1;
      #1;
      chk("async_permit", permit4, 4'b0000);
      chk("async_valid", valid4, 1'b0);
      $display("[TB] async reset mid-cycle -> permit=%b valid=%b", permit4, valid4);
      @(posedge clk);
      #1;
      reset = 1'b0;
      req4 = 4'b1111;
      @(negedge clk);
      chk("async_post_idx", idx4, 2'd0);
      chk("async_post_permit", permit4, 4'b0001);
      $display("[TB] after reset release req=1111 -> idx=%0d", idx4);
      @(posedge clk);
      #1;
      req4 = 4'b0000;

      // randomized run on the 3-requester instance against a reference model
      pulse_reset();
      for (int i = 0; i < 3; i++) begin
         m_cnt[i]  = 0;
         m_wait[i] = 0;
      end
      m_lg = 2;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         req3   = 3'($urandom_range(0, 7));
         full3  = 3'($urandom_range(0, 7));
         stall3 = ($urandom_range(0, 7) == 0);

         elig = stall3 ? 3'b000 : req3;
         for (int i = 0; i < 3; i++) st3[i] = (m_cnt[i] >= 8) && req3[i];
         t1 = elig & st3;
         t2 = elig & full3;
         tier = (t1 != 0) ? t1 : ((t2 != 0) ? t2 : elig);
         e.valid = 1'b0;
         e.idx   = 2'd0;
         for (int k = 1; k <= 3; k++) begin
            int j;
            j = (m_lg + k) % 3;
            if (!e.valid && tier[j]) begin
               e.valid = 1'b1;
               e.idx   = 2'(j);
            end
         end
         e.permit  = e.valid ? (3'b001 << e.idx) : 3'b000;
         e.starved = st3;
         q3.push_back(e);

         @(negedge clk);
         e = q3.pop_front();
         chk("rand_permit",  permit3,  e.permit);
         chk("rand_idx",     idx3,     e.idx);
         chk("rand_starved", starved3, e.starved);
         chk("rand_onehot0", $onehot0(permit3), 1'b1);
         chk("rand_subset",  permit3 & ~req3, 3'b000);
         worst = 0;
         for (int i = 0; i < 3; i++) begin
            if (!req3[i] || permit3[i]) m_wait[i] = 0;
            else if (!stall3) m_wait[i]++;
            if (m_wait[i] > worst) worst = m_wait[i];
         end
         chk("rand_wait_bound", (worst > 8 + 3), 1'b0);
         if (cyc % 1000 == 0)
            $display("[TB] rand cyc %0d req=%b full=%b stall=%b -> permit=%b",
                     cyc, req3, full3, stall3, permit3);

         for (int i = 0; i < 3; i++) begin
            if (!req3[i] || e.permit[i]) m_cnt[i] = 0;
            else if (stall3) m_cnt[i] = m_cnt[i];
            else if (m_cnt[i] < 15) m_cnt[i]++;
         end
         if (e.valid) m_lg = int'(e.idx);
         @(posedge clk);
         #1;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
